// File: rtl/hex_entry_32.sv
// Operator hex-word entry: three debounced active-low buttons shift switch digits into a
// 32-bit edit word and commit it to a held data word with a one-cycle valid pulse.
module hex_entry_32 #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sw_digit,
    input  logic        key_enter_n,
    input  logic        key_commit_n,
    input  logic        key_clear_n,
    output logic [31:0] edit_value,
    output logic [3:0]  digit_count,
    output logic [31:0] data_out,
    output logic        data_valid,
    output logic        full
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit order: 0 = enter, 1 = commit, 2 = clear
    logic [2:0] keys_n;
    logic [2:0] press;

    assign keys_n = {key_clear_n, key_commit_n, key_enter_n};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic             sync1_q, sync1_d;
            logic             sync2_q, sync2_d;
            logic             deb_q, deb_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             press_q, press_d;

            always_comb begin
                sync1_d = keys_n[gi];
                sync2_d = sync1_q;
                deb_d   = deb_q;
                cnt_d   = cnt_q;
                if (sync2_q == deb_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    deb_d = sync2_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Only the released-to-pressed transition of the debounced level counts
                press_d = deb_q & ~deb_d;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                    deb_q   <= 1'b1;
                    cnt_q   <= '0;
                    press_q <= 1'b0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    deb_q   <= deb_d;
                    cnt_q   <= cnt_d;
                    press_q <= press_d;
                end
            end

            assign press[gi] = press_q;
        end
    endgenerate

    state_t      state_q, state_d;
    logic [31:0] edit_q, edit_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;
    logic        full_q, full_d;

    always_comb begin
        state_d      = state_q;
        edit_d       = edit_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;

        if (press[2]) begin
            edit_d  = '0;
            count_d = '0;
        end else if (press[1]) begin
            data_out_d   = edit_q;
            data_valid_d = 1'b1;
            edit_d       = '0;
            count_d      = '0;
        end else if (press[0]) begin
            unique case (state_q)
                EMPTY, ENTRY: begin
                    edit_d  = {edit_q[27:0], sw_digit};
                    count_d = count_q + 4'd1;
                end
                default: begin
                    // FULL: further digits are dropped rather than wrapping
                end
            endcase
        end

        if (count_d == 4'd0) begin
            state_d = EMPTY;
        end else if (count_d == 4'd8) begin
            state_d = FULL;
        end else begin
            state_d = ENTRY;
        end
        full_d = (count_d == 4'd8);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EMPTY;
            edit_q       <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            edit_q       <= edit_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            full_q       <= full_d;
        end
    end

    assign edit_value  = edit_q;
    assign digit_count = count_q;
    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign full        = full_q;

endmodule

// File: tb/tb_hex_entry_32.sv
// Randomised and directed bench for hex_entry_32: a digit-list reference model feeds
// expectation queues that independent monitors drain and compare.
module tb_hex_entry_32;

    localparam int D    = 4;
    localparam int HOLD = D + 6;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sw_digit;
    logic        key_enter_n, key_commit_n, key_clear_n;
    logic [31:0] edit_value;
    logic [3:0]  digit_count;
    logic [31:0] data_out;
    logic        data_valid;
    logic        full;

    hex_entry_32 #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_digit     (sw_digit),
        .key_enter_n  (key_enter_n),
        .key_commit_n (key_commit_n),
        .key_clear_n  (key_clear_n),
        .edit_value   (edit_value),
        .digit_count  (digit_count),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] edit;
        logic [31:0] cnt;
        logic [31:0] full;
        logic [31:0] dout;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] valid_q[$];
    int          total = 0;
    int          bad   = 0;
    event        chk_ev;

    // Reference model: the word is simply the list of entered digits
    int          digits[$];
    logic [31:0] m_dout;

    function automatic logic [31:0] fold_word();
        logic [31:0] v = 0;
        foreach (digits[i]) v = v * 16 + 32'(digits[i]);
        return v;
    endfunction

    // m: {clear, commit, enter}
    task automatic model_apply(input logic [2:0] m, input logic [3:0] d);
        if (m[2]) begin
            digits.delete();
        end else if (m[1]) begin
            m_dout = fold_word();
            valid_q.push_back(m_dout);
            digits.delete();
        end else if (m[0]) begin
            if (digits.size() < 8) digits.push_back(int'(d));
        end
    endtask

    task automatic expect_state(input string tag);
        exp_t e;
        e.edit = fold_word();
        e.cnt  = 32'(digits.size());
        e.full = (digits.size() == 8) ? 32'd1 : 32'd0;
        e.dout = m_dout;
        e.tag  = tag;
        exp_q.push_back(e);
        @(negedge clk);
        -> chk_ev;
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // State monitor: compares whenever the stimulus marks a transaction complete
    always @(chk_ev) begin
        exp_t e;
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: got empty expectation queue want entry", "state_mon");
        end else begin
            e = exp_q.pop_front();
            cmp({e.tag, ".edit"},  edit_value, e.edit);
            cmp({e.tag, ".count"}, 32'(digit_count), e.cnt);
            cmp({e.tag, ".full"},  32'(full), e.full);
            cmp({e.tag, ".dout"},  data_out, e.dout);
        end
    end

    // Commit monitor: every data_valid cycle must match one expected commit
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            if (valid_q.size() == 0) begin
                total++; bad++;
                $display("FAIL data_valid: got pulse data_out=%h want no pulse", data_out);
            end else begin
                cmp("commit.data_out", data_out, valid_q.pop_front());
            end
        end
    end

    task automatic set_keys(input logic [2:0] m);
        key_enter_n  = ~m[0];
        key_commit_n = ~m[1];
        key_clear_n  = ~m[2];
    endtask

    task automatic press(input logic [2:0] m, input logic [3:0] d, input string tag);
        model_apply(m, d);
        sw_digit = d;
        @(negedge clk);
        set_keys(m);
        repeat (HOLD) @(negedge clk);
        set_keys(3'b000);
        repeat (HOLD) @(negedge clk);
        expect_state(tag);
    endtask

    task automatic glitch(input int len, input string tag);
        @(negedge clk);
        key_enter_n = 1'b0;
        repeat (len) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        expect_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] m;
        logic [3:0] d;

        reset = 1'b1; sw_digit = 4'h0; m_dout = 0;
        set_keys(3'b000);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        expect_state("reset");

        // Fill all eight digits, try a ninth, then commit
        for (int i = 1; i <= 8; i++) press(3'b001, 4'(i), "fill");
        press(3'b001, 4'hF, "enter_in_full");
        press(3'b010, 4'h0, "commit_full");

        // Bouncy press: only the settled low level produces a shift
        model_apply(3'b001, 4'h9);
        sw_digit = 4'h9;
        for (int i = 0; i < 6; i++) begin
            key_enter_n = (i % 2 == 1);
            repeat (2) @(negedge clk);
        end
        key_enter_n = 1'b0;
        repeat (HOLD) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (HOLD) @(negedge clk);
        expect_state("bounce");

        glitch(D - 1, "glitch_short");
        model_apply(3'b001, 4'h9);
        glitch(D, "glitch_min");

        press(3'b001, 4'hA, "enter_a");
        press(3'b001, 4'hB, "enter_b");
        press(3'b100, 4'h0, "clear");
        press(3'b001, 4'h1, "enter_1");
        press(3'b001, 4'h2, "enter_2");
        press(3'b110, 4'h0, "clear_commit");
        press(3'b001, 4'h3, "enter_3");
        press(3'b001, 4'h4, "enter_4");
        press(3'b011, 4'h5, "commit_enter");

        // Reset with a press part-way through debouncing
        press(3'b001, 4'hA, "pre_a");
        press(3'b001, 4'hB, "pre_b");
        press(3'b001, 4'hC, "pre_c");
        @(negedge clk);
        key_enter_n = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        key_enter_n = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        digits.delete();
        m_dout = 0;
        repeat (HOLD) @(negedge clk);
        expect_state("mid_reset");
        press(3'b010, 4'h0, "commit_empty");

        for (int n = 0; n < 40; n++) begin
            m = 3'($urandom_range(1, 7));
            if ($urandom_range(0, 2) != 0) m = 3'b001;
            d = 4'($urandom);
            press(m, d, "rand");
        end

        repeat (5) @(negedge clk);
        total++;
        if (valid_q.size() != 0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got pending commits=%0d states=%0d want 0", valid_q.size(), exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
